// File: rtl/mem_dp_pkg.sv
// -----------------------------------------------------------------------------
// mem_dp_pkg
// Shared definitions for the dual-port byte-enable memory:
//   state_t  : init FSM states (IDLE, INIT)
//   RDW_*    : same-address read-during-write policy selectors
//   be_merge : byte-lane merge of an old and a new word under a byte enable
// -----------------------------------------------------------------------------
package mem_dp_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      INIT = 1'b1
   } state_t;

   localparam int RDW_OLD = 0;   // read returns the pre-write word
   localparam int RDW_NEW = 1;   // read returns the merged post-write word

   // The merge works on a fixed maximum width so one function serves every
   // DW; callers widen their operands and truncate the result.
   localparam int MERGE_DW = 256;
   localparam int MERGE_BE = MERGE_DW / 8;

   function automatic logic [MERGE_DW-1:0] be_merge(
      input logic [MERGE_DW-1:0] old_word,
      input logic [MERGE_DW-1:0] new_word,
      input logic [MERGE_BE-1:0] be
   );
      logic [MERGE_DW-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MERGE_BE; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/mem_dp_rd_pipe.sv
// -----------------------------------------------------------------------------
// mem_dp_rd_pipe
// LAT-stage register pipe carrying {valid, data} for the read path.
// The last stage only reloads its data when a valid word arrives, so data_o
// holds the most recent read result between reads.
// Ports:
//   clk_i   : clock (posedge)
//   rst_i   : synchronous active-high flush; clears valid and data
//   valid_i : read accepted this cycle
//   data_i  : word read this cycle
//   valid_o : one-cycle pulse when data_o carries a new word
//   data_o  : read data, held between reads
// -----------------------------------------------------------------------------
module mem_dp_rd_pipe #(
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          valid_o,
   output logic [DW-1:0] data_o
);

   logic [LAT-1:0] valid_q;
   logic [DW-1:0]  data_q [LAT];
   logic [LAT-1:0] valid_d;
   logic [DW-1:0]  data_d [LAT];

   // Stage inputs: stage 0 takes the pipe input, later stages the previous one.
   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_link
         if (gi == 0) begin : g_head
            assign valid_d[gi] = valid_i;
            assign data_d[gi]  = data_i;
         end else begin : g_chain
            assign valid_d[gi] = valid_q[gi-1];
            assign data_d[gi]  = data_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < LAT; i++) begin
            if (i < LAT-1 || valid_d[i]) begin
               data_q[i] <= data_d[i];
            end
         end
      end
   end

   assign valid_o = valid_q[LAT-1];
   assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/mem_dp_be.sv
// -----------------------------------------------------------------------------
// mem_dp_be
// Simple dual-port RAM (one write port, one read port) with per-byte write
// enables, 1- or 2-cycle read latency, selectable read-during-write policy,
// out-of-range detection and an optional zero-fill sequence after reset.
// Ports:
//   CLK, RST  : clock (posedge) and synchronous active-high reset
//   write     : write request; wr_addr / data_in / wr_be qualify it
//   read      : read request at rd_addr
//   data_out  : read data, held between reads
//   rd_valid  : one-cycle pulse when data_out carries new read data
//   busy      : zero-fill in progress, all requests ignored
//   addr_err  : one-cycle pulse after any access to an address >= DEPTH
// -----------------------------------------------------------------------------
module mem_dp_be
   import mem_dp_pkg::*;
#(
   parameter int DW            = 32,
   parameter int AW            = 5,
   parameter int DEPTH         = 2**AW,
   parameter int RD_LATENCY    = 1,
   parameter int RDW_MODE      = 0,
   parameter int INIT_ON_RESET = 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              write,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     data_in,
   input  logic [DW/8-1:0]   wr_be,
   input  logic              read,
   input  logic [AW-1:0]     rd_addr,
   output logic [DW-1:0]     data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              addr_err
);

   localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH-1);
   localparam bit            RDW_IS_NEW = (RDW_MODE == RDW_NEW);
   localparam bit            INIT_EN    = (INIT_ON_RESET != 0);

   logic [DW-1:0] mem_q [DEPTH];
   state_t        state_q;
   logic [AW-1:0] cnt_q;
   logic          busy_q;
   logic          addr_err_q;

   logic          wr_in_range;
   logic          rd_in_range;
   logic          wr_acc;
   logic          rd_acc;
   logic          rdw_hit;
   logic [DW-1:0] wr_merged;
   logic [DW-1:0] rd_data_d;

   assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
   assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
   assign wr_acc      = write && !busy_q && wr_in_range;
   assign rd_acc      = read  && !busy_q && rd_in_range;

   // Word the write port will store: current contents with enabled lanes replaced.
   assign wr_merged = DW'(be_merge(MERGE_DW'(mem_q[wr_addr]), MERGE_DW'(data_in),
                                   MERGE_BE'(wr_be)));

   // In new-data mode a same-address read sees the merged word instead of
   // the array contents, which still hold the pre-write value this cycle.
   assign rdw_hit   = RDW_IS_NEW && wr_acc && (wr_addr == rd_addr);
   assign rd_data_d = rdw_hit ? wr_merged : mem_q[rd_addr];

   // Init FSM: zero-fills one word per cycle, busy drops with the last word.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= INIT_EN ? INIT : IDLE;
         cnt_q   <= '0;
         busy_q  <= INIT_EN;
      end else begin
         case (state_q)
            INIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_ADDR) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Array write port; the reset edge itself never modifies contents.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
         end else if (wr_acc) begin
            mem_q[wr_addr] <= wr_merged;
         end
      end
   end

   // Both ports out of range in one cycle still give a single pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= !busy_q && ((write && !wr_in_range) || (read && !rd_in_range));
      end
   end

   mem_dp_rd_pipe #(
      .DW  (DW),
      .LAT (RD_LATENCY)
   ) u_rd_pipe (
      .clk_i   (CLK),
      .rst_i   (RST),
      .valid_i (rd_acc),
      .data_i  (rd_data_d),
      .valid_o (rd_valid),
      .data_o  (data_out)
   );

   assign busy     = busy_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_dp_be.sv
// -----------------------------------------------------------------------------
// tb_mem_dp_be
// Two instances share one stimulus stream:
//   A : DEPTH=32, RD_LATENCY=1, RDW_MODE=0 (old data)
//   B : DEPTH=20, RD_LATENCY=2, RDW_MODE=1 (new data)
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_dp_be;

   logic        CLK     = 1'b0;
   logic        RST     = 1'b1;
   logic        write   = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] data_in = '0;
   logic [3:0]  wr_be   = '0;
   logic        read    = 1'b0;
   logic [4:0]  rd_addr = '0;

   logic [31:0] data_out_a, data_out_b;
   logic        rd_valid_a, rd_valid_b;
   logic        busy_a, busy_b;
   logic        addr_err_a, addr_err_b;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   mem_dp_be #(
      .DW(32), .AW(5), .DEPTH(32), .RD_LATENCY(1), .RDW_MODE(0), .INIT_ON_RESET(1)
   ) u_dut_a (
      .CLK(CLK), .RST(RST), .write(write), .wr_addr(wr_addr), .data_in(data_in),
      .wr_be(wr_be), .read(read), .rd_addr(rd_addr), .data_out(data_out_a),
      .rd_valid(rd_valid_a), .busy(busy_a), .addr_err(addr_err_a)
   );

   mem_dp_be #(
      .DW(32), .AW(5), .DEPTH(20), .RD_LATENCY(2), .RDW_MODE(1), .INIT_ON_RESET(1)
   ) u_dut_b (
      .CLK(CLK), .RST(RST), .write(write), .wr_addr(wr_addr), .data_in(data_in),
      .wr_be(wr_be), .read(read), .rd_addr(rd_addr), .data_out(data_out_b),
      .rd_valid(rd_valid_b), .busy(busy_b), .addr_err(addr_err_b)
   );

   typedef struct {
      logic        wr;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        rd;
      logic [4:0]  ra;
      logic        a_vld;
      logic [31:0] a_data;
      logic        a_err;
      logic        b_vld;
      logic [31:0] b_data;
      logic        b_err;
   } vec_t;

   vec_t vecs [19];
   vec_t post [2];

   function automatic vec_t mk(input int wr, input int wa, input logic [31:0] wd,
                               input int be, input int rd, input int ra,
                               input int av, input logic [31:0] ad, input int ae,
                               input int bv, input logic [31:0] bd, input int bq);
      vec_t v;
      v.wr = (wr != 0);  v.wa = 5'(wa);  v.wd = wd;  v.be = 4'(be);
      v.rd = (rd != 0);  v.ra = 5'(ra);
      v.a_vld = (av != 0);  v.a_data = ad;  v.a_err = (ae != 0);
      v.b_vld = (bv != 0);  v.b_data = bd;  v.b_err = (bq != 0);
      return v;
   endfunction

   function automatic logic [31:0] val(input int i);
      return 32'h1020_3040 + 32'h0100_0001 * 32'(i);
   endfunction

   task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // One request cycle, then one idle cycle; A answers after the first
   // edge, B after the second. Called right after a falling edge.
   task automatic apply_vec(input string tag, input int idx, input vec_t v);
      write = v.wr;  wr_addr = v.wa;  data_in = v.wd;  wr_be = v.be;
      read  = v.rd;  rd_addr = v.ra;
      @(negedge CLK);
      check_bit ($sformatf("%s%0d a_valid", tag, idx), rd_valid_a, v.a_vld);
      check_word($sformatf("%s%0d a_data", tag, idx), data_out_a, v.a_data);
      check_bit ($sformatf("%s%0d a_err", tag, idx), addr_err_a, v.a_err);
      check_bit ($sformatf("%s%0d b_err", tag, idx), addr_err_b, v.b_err);
      check_bit ($sformatf("%s%0d b_valid_early", tag, idx), rd_valid_b, 1'b0);
      write = 1'b0;
      read  = 1'b0;
      @(negedge CLK);
      check_bit ($sformatf("%s%0d b_valid", tag, idx), rd_valid_b, v.b_vld);
      check_word($sformatf("%s%0d b_data", tag, idx), data_out_b, v.b_data);
      check_bit ($sformatf("%s%0d a_valid_pulse", tag, idx), rd_valid_a, 1'b0);
      check_bit ($sformatf("%s%0d b_err_pulse", tag, idx), addr_err_b, 1'b0);
      $display("%s%0d wr=%0b@%0d be=%h rd=%0b@%0d a_out=%h b_out=%h",
               tag, idx, v.wr, v.wa, v.be, v.rd, v.ra, data_out_a, data_out_b);
   endtask

   // Entered with RST high. Checks the reset state, releases RST, counts busy
   // samples (including the one taken as RST drops) and pokes requests that
   // must all be ignored while busy.
   task automatic init_run(input string tag, output int na, output int nb);
      int qa;
      int qb;
      na = 0;  nb = 0;  qa = 0;  qb = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (i == 0) begin
            check_word({tag, " rst data_out_a"}, data_out_a, 32'h0);
            check_word({tag, " rst data_out_b"}, data_out_b, 32'h0);
            check_bit ({tag, " rst busy_a"}, busy_a, 1'b1);
            check_bit ({tag, " rst busy_b"}, busy_b, 1'b1);
            RST = 1'b0;
         end
         if (busy_a) na++;
         if (busy_b) nb++;
         if (rd_valid_a || addr_err_a) qa++;
         if (rd_valid_b || addr_err_b) qb++;
         write = 1'b0;
         read  = 1'b0;
         if (i >= 5 && i <= 7) begin
            write = 1'b1; wr_addr = 5'd0;  data_in = 32'hFFFF_FFFF; wr_be = 4'hF;
            read  = 1'b1; rd_addr = 5'd0;
         end else if (i >= 8 && i <= 10) begin
            write = 1'b1; wr_addr = 5'd25; data_in = 32'hFFFF_FFFF; wr_be = 4'hF;
            read  = 1'b1; rd_addr = 5'd30;
         end
      end
      check_word({tag, " quiet_a"}, 32'(qa), 32'd0);
      check_word({tag, " quiet_b"}, 32'(qb), 32'd0);
      check_word({tag, " busy_cycles_a"}, 32'(na), 32'd32);
      check_word({tag, " busy_cycles_b"}, 32'(nb), 32'd20);
      $display("%s busy cycles a=%0d b=%0d", tag, na, nb);
   endtask

   initial begin
      int na;
      int nb;
      int pa;
      int pb;

      //             wr wa  wd            be  rd ra  av ad            ae bv bd            be
      vecs[0]  = mk(0, 0,  32'h0,        0,  1, 0,  1, 32'h0,        0, 1, 32'h0,        0);
      vecs[1]  = mk(0, 0,  32'h0,        0,  1, 17, 1, 32'h0,        0, 1, 32'h0,        0);
      vecs[2]  = mk(0, 0,  32'h0,        0,  1, 31, 1, 32'h0,        0, 0, 32'h0,        1);
      vecs[3]  = mk(1, 5,  32'hDEADBEEF, 15, 0, 0,  0, 32'h0,        0, 0, 32'h0,        0);
      vecs[4]  = mk(1, 5,  32'h11223344, 5,  0, 0,  0, 32'h0,        0, 0, 32'h0,        0);
      vecs[5]  = mk(0, 0,  32'h0,        0,  1, 5,  1, 32'hDE22BE44, 0, 1, 32'hDE22BE44, 0);
      vecs[6]  = mk(1, 9,  32'hAAAAAAAA, 15, 0, 0,  0, 32'hDE22BE44, 0, 0, 32'hDE22BE44, 0);
      vecs[7]  = mk(1, 9,  32'h55555555, 15, 1, 9,  1, 32'hAAAAAAAA, 0, 1, 32'h55555555, 0);
      vecs[8]  = mk(1, 9,  32'h12345678, 3,  1, 9,  1, 32'h55555555, 0, 1, 32'h55555678, 0);
      vecs[9]  = mk(0, 0,  32'h0,        0,  1, 9,  1, 32'h55555678, 0, 1, 32'h55555678, 0);
      vecs[10] = mk(1, 25, 32'hFFFFFFFF, 15, 0, 0,  0, 32'h55555678, 0, 0, 32'h55555678, 1);
      vecs[11] = mk(0, 0,  32'h0,        0,  1, 30, 1, 32'h0,        0, 0, 32'h55555678, 1);
      vecs[12] = mk(0, 0,  32'h0,        0,  1, 5,  1, 32'hDE22BE44, 0, 1, 32'hDE22BE44, 0);
      vecs[13] = mk(0, 0,  32'h0,        0,  1, 25, 1, 32'hFFFFFFFF, 0, 0, 32'hDE22BE44, 1);
      vecs[14] = mk(1, 25, 32'h0,        15, 1, 30, 1, 32'h0,        0, 0, 32'hDE22BE44, 1);
      vecs[15] = mk(1, 5,  32'h0,        0,  0, 0,  0, 32'h0,        0, 0, 32'hDE22BE44, 0);
      vecs[16] = mk(0, 0,  32'h0,        0,  1, 5,  1, 32'hDE22BE44, 0, 1, 32'hDE22BE44, 0);
      vecs[17] = mk(1, 1,  32'h0A0B0C0D, 15, 1, 0,  1, 32'h0,        0, 1, 32'h0,        0);
      vecs[18] = mk(0, 0,  32'h0,        0,  1, 1,  1, 32'h0A0B0C0D, 0, 1, 32'h0A0B0C0D, 0);
      // After the second zero-fill every word reads back as zero.
      post[0]  = mk(0, 0,  32'h0,        0,  1, 5,  1, 32'h0,        0, 1, 32'h0,        0);
      post[1]  = mk(0, 0,  32'h0,        0,  1, 0,  1, 32'h0,        0, 1, 32'h0,        0);

      // Two reset edges, then release and zero-fill.
      @(negedge CLK);
      init_run("init", na, nb);

      for (int i = 0; i < 19; i++) begin
         apply_vec("vec", i, vecs[i]);
      end

      // Load addresses 0..7 with distinct words.
      for (int i = 0; i < 8; i++) begin
         write = 1'b1; wr_addr = 5'(i); data_in = val(i); wr_be = 4'hF;
         @(negedge CLK);
      end
      write = 1'b0;

      // Back-to-back reads 0..7: A returns address c-1 at sample c, B c-2.
      pa = 0;  pb = 0;
      for (int c = 0; c < 11; c++) begin
         @(negedge CLK);
         check_bit($sformatf("b2b%0d a_valid", c), rd_valid_a, (c >= 1 && c <= 8));
         check_bit($sformatf("b2b%0d b_valid", c), rd_valid_b, (c >= 2 && c <= 9));
         if (c >= 1 && c <= 8) begin
            check_word($sformatf("b2b%0d a_data", c), data_out_a, val(c-1));
         end
         if (c >= 2 && c <= 9) begin
            check_word($sformatf("b2b%0d b_data", c), data_out_b, val(c-2));
         end
         if (rd_valid_a) pa++;
         if (rd_valid_b) pb++;
         read = (c < 8);
         rd_addr = 5'(c);
         $display("b2b%0d a=%0b:%h b=%0b:%h", c, rd_valid_a, data_out_a, rd_valid_b, data_out_b);
      end
      read = 1'b0;
      check_word("b2b pulses_a", 32'(pa), 32'd8);
      check_word("b2b pulses_b", 32'(pb), 32'd8);

      // Same stream with RST on the edge that would accept address 4: reads
      // of 3 (B) and 4 onwards never appear, outputs clear, busy returns.
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         check_bit($sformatf("mid%0d a_valid", c), rd_valid_a, (c >= 1));
         check_bit($sformatf("mid%0d b_valid", c), rd_valid_b, (c >= 2));
         if (c >= 1) check_word($sformatf("mid%0d a_data", c), data_out_a, val(c-1));
         if (c >= 2) check_word($sformatf("mid%0d b_data", c), data_out_b, val(c-2));
         read = 1'b1;
         rd_addr = 5'(c);
         RST = (c == 4);
         $display("mid%0d a=%0b:%h b=%0b:%h rst=%0b", c, rd_valid_a, data_out_a,
                  rd_valid_b, data_out_b, RST);
      end
      init_run("reinit", na, nb);

      for (int i = 0; i < 2; i++) begin
         apply_vec("post", i, post[i]);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
